// File: rtl/ex_stage.sv
// Execute stage: forwarding, operand select, ALU and the EX/MEM pipeline register.
// Optional iterative multiplier enabled by defining EX_MUL_EN.
module ex_stage #(
    parameter int XLEN    = 32,
    parameter int MUL_CNT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            mem_re_in,
    input  logic            mem_we_in,
    input  logic            reg_file_write_in,
    input  logic [1:0]      alu_op_in,
    input  logic [4:0]      addr_rd_in,
    input  logic [1:0]      select_mux_1_in,
    input  logic [1:0]      select_mux_2_in,
    input  logic [1:0]      select_mux_4_in,
    input  logic [XLEN-1:0] reg_a_in,
    input  logic [XLEN-1:0] reg_b_in,
    input  logic [XLEN-1:0] immediate_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [6:0]      funct7e3_in,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] exmem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            stall_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic            alu_zero_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [4:0]      addr_rd_out,
    output logic            mem_re_out,
    output logic            mem_we_out,
    output logic            reg_file_write_out,
    output logic [1:0]      select_mux_4_out
);

    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic [XLEN-1:0] alu_s;
    logic [4:0]      shamt_s;
    logic [XLEN-1:0] result_s;
    logic            stall_s;
    logic            mul_done_s;
    logic [XLEN-1:0] mul_result_s;
    logic            unused_s;

    // Forwarding muxes followed by operand selection
    always_comb begin
        case (fwd_a_sel)
            2'b01:   fwd_a_s = exmem_fwd_data;
            2'b10:   fwd_a_s = wb_fwd_data;
            default: fwd_a_s = reg_a_in;
        endcase
        case (fwd_b_sel)
            2'b01:   fwd_b_s = exmem_fwd_data;
            2'b10:   fwd_b_s = wb_fwd_data;
            default: fwd_b_s = reg_b_in;
        endcase
        case (select_mux_1_in)
            2'b00:   op_a_s = fwd_a_s;
            2'b01:   op_a_s = pc_in;
            default: op_a_s = {XLEN{1'b0}};
        endcase
        case (select_mux_2_in)
            2'b00:   op_b_s = fwd_b_s;
            2'b01:   op_b_s = immediate_in;
            2'b10:   op_b_s = XLEN'(32'd4);
            default: op_b_s = {XLEN{1'b0}};
        endcase
    end

    // Base ALU; funct7[5] selects sub only for R-type, sra for both R and I
    always_comb begin
        alu_s   = {XLEN{1'b0}};
        shamt_s = op_b_s[4:0];
        case (alu_op_in)
            2'b00: alu_s = op_a_s + op_b_s;
            2'b01: alu_s = op_a_s - op_b_s;
            2'b10, 2'b11: begin
                case (funct7e3_in[2:0])
                    3'b000: begin
                        if (alu_op_in == 2'b10 && funct7e3_in[3]) begin
                            alu_s = op_a_s - op_b_s;
                        end else begin
                            alu_s = op_a_s + op_b_s;
                        end
                    end
                    3'b001: alu_s = op_a_s << shamt_s;
                    3'b010: alu_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
                    3'b011: alu_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
                    3'b100: alu_s = op_a_s ^ op_b_s;
                    3'b101: begin
                        if (funct7e3_in[3]) begin
                            alu_s = $signed(op_a_s) >>> shamt_s;
                        end else begin
                            alu_s = op_a_s >> shamt_s;
                        end
                    end
                    3'b110: alu_s = op_a_s | op_b_s;
                    3'b111: alu_s = op_a_s & op_b_s;
                    default: alu_s = {XLEN{1'b0}};
                endcase
            end
            default: alu_s = op_a_s + op_b_s;
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CNT_W = $clog2(MUL_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    mul_state_t       state_r;
    mul_state_t       state_fsm_s;
    mul_state_t       state_nxt_s;
    logic             stall_fsm_s;
    logic             trigger_s;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  product_r;
    logic [XLEN-1:0]  mul_a_r;
    logic [XLEN-1:0]  mul_b_r;

    assign trigger_s = (alu_op_in == 2'b10) && funct7e3_in[4];

    // Multiplier next-state and stall generation
    always_comb begin
        state_fsm_s = state_r;
        stall_fsm_s = 1'b0;
        mul_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (trigger_s) begin
                    stall_fsm_s = 1'b1;
                    state_fsm_s = BUSY;
                end else begin
                    state_fsm_s = IDLE;
                end
            end
            BUSY: begin
                stall_fsm_s = 1'b1;
                if (cnt_r == CNT_W'(MUL_CNT - 1)) begin
                    state_fsm_s = DONE;
                end else begin
                    state_fsm_s = BUSY;
                end
            end
            DONE: begin
                mul_done_s  = 1'b1;
                state_fsm_s = IDLE;
            end
            default: state_fsm_s = IDLE;
        endcase
    end

    // A flushed instruction never stalls and always lands the FSM in IDLE
    assign state_nxt_s  = flush ? IDLE : state_fsm_s;
    assign stall_s      = stall_fsm_s & ~flush;
    assign mul_result_s = (funct7e3_in[2:0] == 3'b000) ? product_r : {XLEN{1'b0}};
    assign unused_s     = ^funct7e3_in[6:5];

    // Shift-and-add datapath: operands latched once, forwarding ignored afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {XLEN{1'b0}};
            mul_a_r   <= {XLEN{1'b0}};
            mul_b_r   <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (!flush && state_r == IDLE && trigger_s) begin
                mul_a_r   <= op_a_s;
                mul_b_r   <= op_b_s;
                product_r <= {XLEN{1'b0}};
                cnt_r     <= {CNT_W{1'b0}};
            end else if (!flush && state_r == BUSY) begin
                if (mul_b_r[cnt_r]) begin
                    product_r <= product_r + (mul_a_r << cnt_r);
                end else begin
                    product_r <= product_r;
                end
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end
`else
    assign stall_s      = 1'b0;
    assign mul_done_s   = 1'b0;
    assign mul_result_s = {XLEN{1'b0}};
    assign unused_s     = ^{funct7e3_in[6:4], 32'(MUL_CNT)};
`endif

    assign result_s  = mul_done_s ? mul_result_s : alu_s;
    assign stall_out = stall_s;

    // EX/MEM pipeline register; flush and non-final stall cycles insert a bubble
    always_ff @(posedge clk) begin
        if (reset || flush || stall_s) begin
            alu_result_out     <= {XLEN{1'b0}};
            alu_zero_out       <= 1'b0;
            store_data_out     <= {XLEN{1'b0}};
            addr_rd_out        <= 5'd0;
            mem_re_out         <= 1'b0;
            mem_we_out         <= 1'b0;
            reg_file_write_out <= 1'b0;
            select_mux_4_out   <= 2'b00;
        end else begin
            alu_result_out     <= result_s;
            alu_zero_out       <= (result_s == {XLEN{1'b0}});
            store_data_out     <= fwd_b_s;
            addr_rd_out        <= addr_rd_in;
            mem_re_out         <= mem_re_in;
            mem_we_out         <= mem_we_in;
            reg_file_write_out <= reg_file_write_in;
            select_mux_4_out   <= select_mux_4_in;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; adapts expectations to EX_MUL_EN.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, flush, mem_re_in, mem_we_in, reg_file_write_in;
    logic [1:0]  alu_op_in, select_mux_1_in, select_mux_2_in, select_mux_4_in;
    logic [4:0]  addr_rd_in;
    logic [31:0] reg_a_in, reg_b_in, immediate_in, pc_in;
    logic [6:0]  funct7e3_in;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] exmem_fwd_data, wb_fwd_data;
    logic        stall_out, alu_zero_out, mem_re_out, mem_we_out, reg_file_write_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [4:0]  addr_rd_out;
    logic [1:0]  select_mux_4_out;

    int tests_run    = 0;
    int tests_failed = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .mem_re_in(mem_re_in), .mem_we_in(mem_we_in), .reg_file_write_in(reg_file_write_in),
        .alu_op_in(alu_op_in), .addr_rd_in(addr_rd_in),
        .select_mux_1_in(select_mux_1_in), .select_mux_2_in(select_mux_2_in),
        .select_mux_4_in(select_mux_4_in),
        .reg_a_in(reg_a_in), .reg_b_in(reg_b_in), .immediate_in(immediate_in), .pc_in(pc_in),
        .funct7e3_in(funct7e3_in), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .exmem_fwd_data(exmem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .stall_out(stall_out), .alu_result_out(alu_result_out), .alu_zero_out(alu_zero_out),
        .store_data_out(store_data_out), .addr_rd_out(addr_rd_out),
        .mem_re_out(mem_re_out), .mem_we_out(mem_we_out),
        .reg_file_write_out(reg_file_write_out), .select_mux_4_out(select_mux_4_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        flush = 1'b0; mem_re_in = 1'b0; mem_we_in = 1'b0; reg_file_write_in = 1'b0;
        alu_op_in = 2'b00; addr_rd_in = 5'd0; select_mux_1_in = 2'b00; select_mux_2_in = 2'b00;
        select_mux_4_in = 2'b00; reg_a_in = 32'd0; reg_b_in = 32'd0; immediate_in = 32'd0;
        pc_in = 32'd0; funct7e3_in = 7'd0; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        exmem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
    endtask

    // Wait while stall_out is high, counting stalled cycles and non-bubble outputs
    task automatic wait_stall(output int cycles, output int bad_bubbles);
        cycles = 0;
        bad_bubbles = 0;
        while (stall_out === 1'b1 && cycles < 200) begin
            cycles++;
            step();
            if (stall_out === 1'b1 && reg_file_write_out !== 1'b0) bad_bubbles++;
        end
    endtask

    int cyc, bad;

    initial begin
        drive_nop();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // traffic, then reset held 2 cycles with traffic still present
        reg_a_in = 32'd1; reg_b_in = 32'd2; reg_file_write_in = 1'b1; mem_re_in = 1'b1;
        addr_rd_in = 5'd3; select_mux_4_in = 2'b10;
        step();
        check_val("pre_reset_add", alu_result_out, 32'd3);
        reset = 1'b1;
        step(); step();
        check_val("rst_result", alu_result_out, 32'd0);
        check_val("rst_ctrl", {27'd0, mem_re_out, mem_we_out, reg_file_write_out, select_mux_4_out},
                  32'd0);
        check_val("rst_rd", {27'd0, addr_rd_out}, 32'd0);
        check_val("rst_stall", {31'd0, stall_out}, 32'd0);
        reset = 1'b0;

        // R-type sub 5-7
        drive_nop();
        alu_op_in = 2'b10; funct7e3_in = 7'b0001000; reg_a_in = 32'd5; reg_b_in = 32'd7;
        mem_we_in = 1'b1; reg_file_write_in = 1'b1; addr_rd_in = 5'd9; select_mux_4_in = 2'b01;
        step();
        check_val("rsub_result", alu_result_out, 32'hFFFF_FFFE);
        check_val("rsub_zero", {31'd0, alu_zero_out}, 32'd0);
        check_val("rsub_ctrl", {25'd0, addr_rd_out, mem_re_out, mem_we_out, reg_file_write_out},
                  {25'd0, 5'd9, 3'b011});
        check_val("rsub_mux4", {30'd0, select_mux_4_out}, 32'd1);
        check_val("rsub_store", store_data_out, 32'd7);

        // forwarding A from EX/MEM, immediate B; store data from WB forward
        drive_nop();
        fwd_a_sel = 2'b01; exmem_fwd_data = 32'h10; reg_a_in = 32'hDEAD; immediate_in = 32'd4;
        select_mux_2_in = 2'b01; fwd_b_sel = 2'b10; wb_fwd_data = 32'h55; reg_b_in = 32'h99;
        step();
        check_val("fwd_add", alu_result_out, 32'h14);
        check_val("fwd_store", store_data_out, 32'h55);

        // I-type shifts right, arithmetic then logical
        drive_nop();
        alu_op_in = 2'b11; funct7e3_in = 7'b0001101; reg_a_in = 32'h8000_0000;
        immediate_in = 32'd4; select_mux_2_in = 2'b01;
        step();
        check_val("srai", alu_result_out, 32'hF800_0000);
        funct7e3_in = 7'b0000101;
        step();
        check_val("srli", alu_result_out, 32'h0800_0000);

        // sub to zero sets zero flag
        drive_nop();
        alu_op_in = 2'b01; reg_a_in = 32'd9; reg_b_in = 32'd9;
        step();
        check_val("sub_zero_res", alu_result_out, 32'd0);
        check_val("sub_zero_flag", {31'd0, alu_zero_out}, 32'd1);

        // signed vs unsigned compare of -1 and 1
        drive_nop();
        alu_op_in = 2'b10; funct7e3_in = 7'b0000010; reg_a_in = 32'hFFFF_FFFF; reg_b_in = 32'd1;
        step();
        check_val("slt", alu_result_out, 32'd1);
        funct7e3_in = 7'b0000011;
        step();
        check_val("sltu", alu_result_out, 32'd0);

        // pc + 4, I-type add ignores f7[5]
        drive_nop();
        select_mux_1_in = 2'b01; pc_in = 32'h100; select_mux_2_in = 2'b10;
        step();
        check_val("pc_plus4", alu_result_out, 32'h104);
        drive_nop();
        alu_op_in = 2'b11; funct7e3_in = 7'b0001000; reg_a_in = 32'd10; immediate_in = 32'd3;
        select_mux_2_in = 2'b01;
        step();
        check_val("addi_f7", alu_result_out, 32'd13);

        // flush inserts bubble
        drive_nop();
        reg_a_in = 32'd1; reg_b_in = 32'd1; reg_file_write_in = 1'b1; mem_we_in = 1'b1; flush = 1'b1;
        step();
        check_val("flush_ctrl", {29'd0, mem_re_out, mem_we_out, reg_file_write_out}, 32'd0);
        check_val("flush_data", alu_result_out, 32'd0);

        // multiply 0xFFFFFFFF * 3
        drive_nop();
        alu_op_in = 2'b10; funct7e3_in = 7'b0010000; reg_a_in = 32'hFFFF_FFFF; reg_b_in = 32'd3;
        reg_file_write_in = 1'b1; addr_rd_in = 5'd7;
`ifdef EX_MUL_EN
        #1;
        check_val("mul_stall_c0", {31'd0, stall_out}, 32'd1);
        wait_stall(cyc, bad);
        check_val("mul_stall_len", cyc, 32'd33);
        check_val("mul_bubbles", bad, 32'd0);
        step();
        check_val("mul_result", alu_result_out, 32'hFFFF_FFFD);
        check_val("mul_ctrl", {26'd0, addr_rd_out, reg_file_write_out}, {26'd0, 5'd7, 1'b1});

        // back-to-back MULH-type op: result 0, controls intact
        funct7e3_in = 7'b0010001; reg_a_in = 32'd5; reg_b_in = 32'd6;
        #1;
        check_val("mul2_stall_c0", {31'd0, stall_out}, 32'd1);
        wait_stall(cyc, bad);
        check_val("mul2_stall_len", cyc, 32'd33);
        step();
        check_val("mul2_result", alu_result_out, 32'd0);
        check_val("mul2_zero", {31'd0, alu_zero_out}, 32'd1);
        check_val("mul2_write", {31'd0, reg_file_write_out}, 32'd1);

        // flush during BUSY aborts the multiply
        funct7e3_in = 7'b0010000; reg_a_in = 32'hFFFF_FFFF; reg_b_in = 32'd3;
        for (int i = 0; i < 11; i++) step();
        check_val("flush_busy_stall", {31'd0, stall_out}, 32'd1);
        alu_op_in = 2'b00; funct7e3_in = 7'd0; reg_a_in = 32'd1; reg_b_in = 32'd1; flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("flush_mul_stall", {31'd0, stall_out}, 32'd0);
        check_val("flush_mul_bubble", {31'd0, reg_file_write_out}, 32'd0);
        step();
        check_val("post_flush_add", alu_result_out, 32'd2);
        check_val("post_flush_wr", {31'd0, reg_file_write_out}, 32'd1);
`else
        #1;
        check_val("nomul_stall", {31'd0, stall_out}, 32'd0);
        step();
        check_val("nomul_add", alu_result_out, 32'h0000_0002);
        check_val("nomul_wr", {31'd0, reg_file_write_out}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
